// File: rtl/mips_pkg.sv
// Shared encodings, control bundle and decode helpers for the 5-stage MIPS-subset pipeline.
package mips_pkg;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLL   = 6'h00;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_ID,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_imm;
    logic    imm_zext;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Unsupported opcodes and functs fall through as CTRL_NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_R: begin
        c.reg_write = 1'b1;
        case (funct)
          FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLL:  c.alu_op = ALU_SLL;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_ADDIU: begin
        c.reg_write = 1'b1;
        c.alu_imm   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_ORI: begin
        c.reg_write = 1'b1;
        c.alu_imm   = 1'b1;
        c.imm_zext  = 1'b1;
        c.alu_op    = ALU_OR;
      end
      OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_imm   = 1'b1;
        c.alu_op    = ALU_LUI;
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_imm   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_imm   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_BEQ:  c.branch = 1'b1;
      OP_J:    c.jump   = 1'b1;
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

  // Instructions whose rt field is a true source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_R) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_pipeline_regfile.sv
// 32x32 register file: two combinational read ports with WB bypass, one write port, $0 hard-wired.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0][31:0] regs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle WB write is visible to ID without waiting for the edge.
  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == 5'd0) begin
      rdata_a = '0;
    end else if (we && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == 5'd0) begin
      rdata_b = '0;
    end else if (we && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end
  end

endmodule

// File: rtl/mips_pipeline.sv
// 5-stage MIPS-subset core: IF/ID/EX/MEM/WB with EX forwarding, load-use stall and EX-resolved control flow.
module mips_pipeline
  import mips_pkg::*;
#(
  parameter string       IMEM_FILE  = "code.txt",
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  initial begin
    for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = NOP;
  end

  function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                          input logic       mem_we, input logic [4:0] mem_dest,
                                          input logic       wb_we,  input logic [4:0] wb_dest);
    if (src == 5'd0)                         return FWD_ID;
    else if (mem_we && (mem_dest == src))    return FWD_EXMEM;
    else if (wb_we && (wb_dest == src))      return FWD_MEMWB;
    else                                     return FWD_ID;
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [4:0] shamt);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: return b << shamt;
      ALU_LUI: return {b[15:0], 16'h0000};
      default: return '0;
    endcase
  endfunction

  logic [31:0] pc, pc4_if, instr_if;
  logic [31:0] ifid_instr, ifid_pc4;
  ctrl_t       idex_ctrl;
  logic [31:0] idex_pc4, idex_rs_val, idex_rt_val;
  logic [25:0] idex_fields;
  logic [4:0]  idex_dest;
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write;
  logic [31:0] exmem_result, exmem_store;
  logic [4:0]  exmem_dest;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_data;

  logic        stall, taken;
  logic [31:0] target_ex;

  // ---- IF ----
  assign pc4_if   = pc + 32'd4;
  assign instr_if = imem[pc[IAW+1:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      ifid_instr <= NOP;
      ifid_pc4   <= '0;
    end else if (taken) begin
      pc         <= target_ex;
      ifid_instr <= NOP;
      ifid_pc4   <= '0;
    end else if (!stall) begin
      pc         <= pc4_if;
      ifid_instr <= instr_if;
      ifid_pc4   <= pc4_if;
    end
  end

  // ---- ID ----
  logic [5:0]  op_id;
  logic [4:0]  rs_id, rt_id, dest_id;
  ctrl_t       ctrl_id;
  logic [31:0] rs_val_id, rt_val_id;

  assign op_id   = ifid_instr[31:26];
  assign rs_id   = ifid_instr[25:21];
  assign rt_id   = ifid_instr[20:16];
  assign dest_id = (op_id == OP_R) ? ifid_instr[15:11] : rt_id;

  // A write aimed at $0 is dropped here, so later stages never forward it.
  always_comb begin
    ctrl_id = decode(op_id, ifid_instr[5:0]);
    if (dest_id == 5'd0) ctrl_id.reg_write = 1'b0;
  end

  mips_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs_id),
    .rdata_a (rs_val_id),
    .raddr_b (rt_id),
    .rdata_b (rt_val_id),
    .we      (memwb_reg_write),
    .waddr   (memwb_dest),
    .wdata   (memwb_data)
  );

  logic [4:0] rs_ex, rt_ex;
  assign rs_ex = idex_fields[25:21];
  assign rt_ex = idex_fields[20:16];

  assign stall = idex_ctrl.mem_read &&
                 ((rt_ex == rs_id) || (uses_rt(op_id) && (rt_ex == rt_id)));

  // A taken branch/jump flushes; it also overrides any stall detected this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_ctrl   <= CTRL_NOP;
      idex_pc4    <= '0;
      idex_rs_val <= '0;
      idex_rt_val <= '0;
      idex_fields <= '0;
      idex_dest   <= '0;
    end else if (taken || stall) begin
      idex_ctrl   <= CTRL_NOP;
      idex_pc4    <= '0;
      idex_rs_val <= '0;
      idex_rt_val <= '0;
      idex_fields <= '0;
      idex_dest   <= '0;
    end else begin
      idex_ctrl   <= ctrl_id;
      idex_pc4    <= ifid_pc4;
      idex_rs_val <= rs_val_id;
      idex_rt_val <= rt_val_id;
      idex_fields <= ifid_instr[25:0];
      idex_dest   <= dest_id;
    end
  end

  // ---- EX ----
  fwd_sel_t    fwd_a, fwd_b;
  logic [31:0] op_a, op_b, imm_ex, alu_b, result_ex;

  assign fwd_a = fwd_select(rs_ex, exmem_reg_write, exmem_dest, memwb_reg_write, memwb_dest);
  assign fwd_b = fwd_select(rt_ex, exmem_reg_write, exmem_dest, memwb_reg_write, memwb_dest);

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: op_a = exmem_result;
      FWD_MEMWB: op_a = memwb_data;
      default:   op_a = idex_rs_val;
    endcase
    case (fwd_b)
      FWD_EXMEM: op_b = exmem_result;
      FWD_MEMWB: op_b = memwb_data;
      default:   op_b = idex_rt_val;
    endcase
  end

  assign imm_ex    = idex_ctrl.imm_zext ? {16'h0000, idex_fields[15:0]}
                                        : {{16{idex_fields[15]}}, idex_fields[15:0]};
  assign alu_b     = idex_ctrl.alu_imm ? imm_ex : op_b;
  assign result_ex = alu(idex_ctrl.alu_op, op_a, alu_b, idex_fields[10:6]);

  assign taken     = idex_ctrl.jump || (idex_ctrl.branch && (op_a == op_b));
  assign target_ex = idex_ctrl.jump ? {idex_pc4[31:28], idex_fields, 2'b00}
                                    : idex_pc4 + {imm_ex[29:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_result    <= '0;
      exmem_store     <= '0;
      exmem_dest      <= '0;
    end else begin
      exmem_reg_write <= idex_ctrl.reg_write;
      exmem_mem_read  <= idex_ctrl.mem_read;
      exmem_mem_write <= idex_ctrl.mem_write;
      exmem_result    <= result_ex;
      exmem_store     <= op_b;
      exmem_dest      <= idex_dest;
    end
  end

  // ---- MEM ----
  logic [31:0] load_data, wb_data_mem;

  assign load_data   = dmem[exmem_result[DAW+1:2]];
  assign wb_data_mem = exmem_mem_read ? load_data : exmem_result;

  always_ff @(posedge clk) begin
    if (exmem_mem_write) dmem[exmem_result[DAW+1:2]] <= exmem_store;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_reg_write <= 1'b0;
      memwb_dest      <= '0;
      memwb_data      <= '0;
    end else begin
      memwb_reg_write <= exmem_reg_write;
      memwb_dest      <= exmem_dest;
      memwb_data      <= wb_data_mem;
    end
  end

  // ---- WB ----
  assign pc_o      = pc;
  assign wb_en_o   = memwb_reg_write;
  assign wb_addr_o = memwb_dest;
  assign wb_data_o = memwb_data;

endmodule

// File: tb/tb_mips_pipeline.sv
// Bench for mips_pipeline: directed hazard program plus random programs checked against an ISA-level model.
module tb_mips_pipeline;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  mips_pipeline #(.IMEM_FILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_o      (pc_o),
    .wb_en_o   (wb_en_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input int idx);
    return {6'h02, 26'(idx)};
  endfunction

  logic [31:0] rom   [1024];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [1024];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          touched[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [31:0] pc_trace[$];

  initial for (int i = 0; i < 1024; i++) m_mem[i] = '0;

  // Sequential ISA interpreter: one instruction at a time, no pipeline notion.
  task automatic run_model();
    logic [31:0] pc, npc, ins, a, b, se, v, ea;
    logic [4:0]  d;
    logic        wr;
    bit          done;
    pc = 0;
    done = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    exp_addr.delete(); exp_data.delete(); touched.delete();
    for (int step = 0; step < 20000 && !done; step++) begin
      ins = rom[(pc >> 2) & 32'h3FF];
      a   = m_reg[ins[25:21]];
      b   = m_reg[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ea  = a + se;
      npc = pc + 4;
      wr  = 0;
      d   = ins[20:16];
      v   = '0;
      case (ins[31:26])
        6'h00: begin
          d  = ins[15:11];
          wr = 1;
          case (ins[5:0])
            6'h21: v = a + b;
            6'h23: v = a - b;
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: v = b << ins[10:6];
            default: wr = 0;
          endcase
        end
        6'h09: begin wr = 1; v = a + se; end
        6'h0D: begin wr = 1; v = a | {16'h0, ins[15:0]}; end
        6'h0F: begin wr = 1; v = {ins[15:0], 16'h0}; end
        6'h23: begin wr = 1; v = m_mem[(ea >> 2) & 32'h3FF]; end
        6'h2B: begin
          m_mem[(ea >> 2) & 32'h3FF] = b;
          touched.push_back(int'((ea >> 2) & 32'h3FF));
        end
        6'h04: if (a == b) npc = pc + 4 + (se << 2);
        6'h02: begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          if (npc == pc) done = 1;
        end
        default: ;
      endcase
      if (wr && d != 0) begin
        m_reg[d] = v;
        exp_addr.push_back(int'(d));
        exp_data.push_back(v);
      end
      pc = npc;
    end
    if (!done) check_val("model_terminated", 32'd0, 32'd1);
  endtask

  task automatic run_dut(input bit first, input int cycles);
    int nz;
    if (!first) begin
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.u_regfile.regs[i] != 0) nz++;
      check_val("async_rst_pc", pc_o, 32'd0);
      check_val("async_rst_wb_en", 32'(wb_en_o), 32'd0);
      check_val("async_rst_nonzero_regs", nz, 32'd0);
    end
    for (int i = 0; i < 1024; i++) dut.imem[i] = rom[i];
    @(posedge clk);
    #1;
    check_val("rst_pc", pc_o, 32'd0);
    check_val("rst_wb_data", wb_data_o, 32'd0);
    if (first) while ($time < 100) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_addr.delete(); got_data.delete(); got_cyc.delete(); pc_trace.delete();
    for (int c = 0; c < cycles; c++) begin
      pc_trace.push_back(pc_o);
      if (wb_en_o) begin
        got_addr.push_back(int'(wb_addr_o));
        got_data.push_back(wb_data_o);
        got_cyc.push_back(c);
      end
      @(negedge clk);
    end
  endtask

  task automatic compare_run(input string name);
    check_val({name, "_wb_count"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check_val($sformatf("%s_wb%0d_addr", name, i), got_addr[i], exp_addr[i]);
      check_val($sformatf("%s_wb%0d_data", name, i), got_data[i], exp_data[i]);
    end
    for (int i = 0; i < 32; i++)
      check_val($sformatf("%s_reg%0d", name, i), dut.u_regfile.regs[i], m_reg[i]);
    foreach (touched[k])
      check_val($sformatf("%s_dmem%0d", name, touched[k]), dut.dmem[touched[k]], m_mem[touched[k]]);
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    rom[0]  = enc_i(6'h0D, 5'd0, 5'd1, 16'd5);          // ori  $1,$0,5
    rom[1]  = enc_r(6'h21, 5'd2, 5'd1, 5'd1, 5'd0);      // addu $2,$1,$1
    rom[2]  = enc_r(6'h23, 5'd3, 5'd2, 5'd1, 5'd0);      // subu $3,$2,$1
    rom[3]  = enc_i(6'h2B, 5'd0, 5'd2, 16'd0);           // sw   $2,0($0)
    rom[4]  = enc_i(6'h23, 5'd0, 5'd4, 16'd0);           // lw   $4,0($0)
    rom[5]  = enc_r(6'h21, 5'd5, 5'd4, 5'd4, 5'd0);      // addu $5,$4,$4
    rom[6]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);           // beq  $1,$1,+2
    rom[7]  = enc_i(6'h0D, 5'd0, 5'd6, 16'd6);
    rom[8]  = enc_i(6'h0D, 5'd0, 5'd6, 16'd6);
    rom[9]  = enc_i(6'h0D, 5'd0, 5'd7, 16'd7);
    rom[10] = enc_i(6'h0F, 5'd0, 5'd8, 16'h8000);        // lui  $8,0x8000
    rom[11] = enc_r(6'h2A, 5'd9, 5'd8, 5'd0, 5'd0);      // slt  $9,$8,$0
    rom[12] = enc_j(12);                                 // j    self
  endtask

  task automatic check_directed();
    int exp_cyc [8] = '{4, 5, 6, 8, 10, 14, 15, 16};
    check_val("dir_pc_c0", pc_trace[0], 32'd0);
    check_val("dir_pc_c1", pc_trace[1], 32'd4);
    check_val("dir_pc_c2", pc_trace[2], 32'd8);
    check_val("dir_wb_count", got_cyc.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_cyc.size(); i++)
      check_val($sformatf("dir_wb_cycle%0d", i), got_cyc[i], exp_cyc[i]);
    check_val("dir_branch_target_pc", pc_trace[10], 32'd36);
    check_val("dir_loop_pc_a", pc_trace[16], 32'd48);
    check_val("dir_loop_pc_b", pc_trace[19], 32'd48);
    check_val("dir_r2", dut.u_regfile.regs[2], 32'd10);
    check_val("dir_r3", dut.u_regfile.regs[3], 32'd5);
    check_val("dir_dmem0", dut.dmem[0], 32'd10);
    check_val("dir_r5", dut.u_regfile.regs[5], 32'd20);
    check_val("dir_r6", dut.u_regfile.regs[6], 32'd0);
    check_val("dir_r7", dut.u_regfile.regs[7], 32'd7);
    check_val("dir_r8", dut.u_regfile.regs[8], 32'h8000_0000);
    check_val("dir_r9", dut.u_regfile.regs[9], 32'd1);
  endtask

  task automatic gen_random(input int n);
    logic [4:0]  rd, rs, rt, sh;
    logic [15:0] imm;
    int          off, tgt;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    for (int i = 0; i < n; i++) begin
      rd  = 5'($urandom_range(0, 7));
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      sh  = 5'($urandom_range(0, 31));
      imm = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 13))
        0:  rom[i] = enc_r(6'h21, rd, rs, rt, 5'd0);
        1:  rom[i] = enc_r(6'h23, rd, rs, rt, 5'd0);
        2:  rom[i] = enc_r(6'h24, rd, rs, rt, 5'd0);
        3:  rom[i] = enc_r(6'h25, rd, rs, rt, 5'd0);
        4:  rom[i] = enc_r(6'h2A, rd, rs, rt, 5'd0);
        5:  rom[i] = enc_r(6'h00, rd, 5'd0, rt, sh);
        6:  rom[i] = enc_i(6'h09, rs, rt, imm);
        7:  rom[i] = enc_i(6'h0D, rs, rt, imm);
        8:  rom[i] = enc_i(6'h0F, 5'd0, rt, imm);
        9, 10: rom[i] = enc_i(6'h23, $urandom_range(0, 1) ? 5'd0 : rs, rt, 16'($urandom_range(0, 15) * 4));
        11: rom[i] = enc_i(6'h2B, $urandom_range(0, 1) ? 5'd0 : rs, rt, 16'($urandom_range(0, 15) * 4));
        12: begin
          off = $urandom_range(0, 3);
          if (off > n - (i + 1)) off = n - (i + 1);
          rom[i] = enc_i(6'h04, rs, rt, 16'(off));
        end
        default: begin
          case ($urandom_range(0, 2))
            0: begin
              tgt = $urandom_range(i + 1, n);
              rom[i] = enc_j(tgt);
            end
            1: rom[i] = {6'h3F, 26'($urandom)};
            default: rom[i] = enc_r(6'h3B, rd, rs, rt, 5'd0);
          endcase
        end
      endcase
    end
    rom[n] = enc_j(n);
  endtask

  initial begin
    load_directed();
    run_model();
    run_dut(1'b1, 80);
    compare_run("dir");
    check_directed();

    load_directed();
    run_model();
    run_dut(1'b0, 80);
    compare_run("dir_rerun");
    check_directed();

    for (int p = 0; p < 6; p++) begin
      gen_random(40);
      run_model();
      run_dut(1'b0, 3 * 40 + 40);
      compare_run($sformatf("rnd%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
